blackjack_table_fsm: RTL and testbench
======================================

Name: blackjack_table_fsm

Overview:
Parametrised blackjack game controller and the successor to the single-hand player FSM. It deals to both player and dealer from an external card source through a req/valid handshake. It tracks both hands with soft-ace scoring, runs dealer auto-play, and resolves the winner. It sits between the mouse/button decoder, the card generator and the card-drawing VGA stage.

Parameters:
MAX_CARDS, 9, card slots per hand (2..15)
SCORE_W, 6, width of score outputs
DEALER_STAND, 17, dealer stands at or above this total

Ports:
clk  in  1  posedge clock
rst  in  1  asynchronous reset, active-low (0 = reset)
deal  in  1  level; rising edge starts a round
hit  in  1  level; rising edge requests a player card
stand  in  1  level; rising edge ends player turn
card_valid  in  1  card source has a card
card_value  in  4  1=ace, 2..10, 11..13 = J/Q/K
card_symbol  in  2  suit
card_req  out  1  card request to source
player_values  out  4*MAX_CARDS  player hand values, slot i at [4i+3:4i]
player_symbols  out  2*MAX_CARDS  player hand suits
dealer_values  out  4*MAX_CARDS  dealer hand values
dealer_symbols  out  2*MAX_CARDS  dealer hand suits
player_count  out  4  cards in player hand
dealer_count  out  4  cards in dealer hand
player_score  out  SCORE_W  best player total
dealer_score  out  SCORE_W  best dealer total
state_btn  out  3  0 = deal button, 1 = hit/stand, 2 = dealer playing, 3 = result shown
result  out  2  0 = none, 1 = player wins, 2 = dealer wins, 3 = push

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, card_req=0, edge-detect registers cleared. Reset mid-handshake drops card_req immediately.
- deal/hit/stand are edge-detected internally. A held level triggers at most once. Edges outside the relevant state are discarded.
- Card points: ace=1, 2..10 face value, 11..13=10. Score = sum of points, plus 10 if the hand holds an ace and sum+10<=21. Score is saturated to SCORE_W.
- Scores are registered and lag the hand/count update by 1 cycle. FSM decisions use the next-cycle (post-update) score.
- Handshake: card_req is held high until a cycle with card_req&card_valid. The card is written to slot [count] and count increments in that cycle. card_req is low the next cycle. card_valid without card_req is ignored.
- FSM states and transitions:
  - IDLE: on deal edge, clear both hands and result, then go to DEAL.
  - DEAL: fetch 4 cards in order player, dealer, player, dealer, then go to CHECK_NATURAL.
  - CHECK_NATURAL: if player_score==21, go to DEALER_TURN; else go to PLAYER_TURN.
  - PLAYER_TURN (state_btn=1): stand edge goes to DEALER_TURN. hit edge goes to PLAYER_DRAW. If hit and stand edges arrive in the same cycle, stand wins.
  - PLAYER_DRAW: fetch 1 card, then go to PLAYER_CHECK.
  - PLAYER_CHECK: score>21 goes to RESOLVE (dealer does not draw). score==21 or player_count==MAX_CARDS goes to DEALER_TURN (auto-stand). Otherwise go to PLAYER_TURN.
  - DEALER_TURN (state_btn=2): if dealer_score<DEALER_STAND and dealer_count<MAX_CARDS, go to DEALER_DRAW; else go to RESOLVE.
  - DEALER_DRAW: fetch 1 card, wait 1 cycle for score, then go to DEALER_TURN.
  - RESOLVE: player bust gives 2; else dealer bust gives 1; else higher score wins; equal scores give 3. Then go to DONE.
  - DONE (state_btn=3): result held. A deal edge clears hands and goes to DEAL.
- Unused hand slots read 0. count never exceeds MAX_CARDS.

Optional Feature:
DEALER_HIT_SOFT17_EN. When defined, the dealer also draws at a soft total equal to DEALER_STAND (ace counted as 11). This needs an internal soft flag. When undefined, the dealer stands on any total >= DEALER_STAND.

Test Plan:
- Reset mid-DEAL with card_req=1: rst=0 -> card_req=0, counts 0, state_btn=0, result=0 asynchronously.
- deal edge, source cards 10,5,9,7 (player gets 10,9; dealer gets 5,7); stand; dealer draws 8 -> dealer_score=20, player_score=19, result=2, dealer_count=3.
- Player 10,6 then hit with 9 -> player_score=25, result=2, no further card_req, dealer_count=2.
- Player ace,K -> player_score=21, hit/stand buttons skipped (state_btn goes 0->2), dealer 10,7 -> result=1.
- Hold hit high for 100 cycles -> exactly one card added. Hit and stand edges in the same cycle -> no card added, dealer turn entered.
- Dealer ace,6 (soft 17): undefined macro -> dealer_count=2; with DEALER_HIT_SOFT17_EN -> one more card_req. card_valid delayed 50 cycles -> card_req stays high throughout.

Source files
------------

// File: rtl/blackjack_table_fsm.sv
// blackjack_table_fsm: two-hand blackjack round controller with req/valid card fetch and soft-ace scoring.
// Define DEALER_HIT_SOFT17_EN to make the dealer also draw on a soft DEALER_STAND total.
module blackjack_table_fsm #(
  parameter int MAX_CARDS    = 9,
  parameter int SCORE_W      = 6,
  parameter int DEALER_STAND = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   deal,
  input  logic                   hit,
  input  logic                   stand,
  input  logic                   card_valid,
  input  logic [3:0]             card_value,
  input  logic [1:0]             card_symbol,
  output logic                   card_req,
  output logic [4*MAX_CARDS-1:0] player_values,
  output logic [2*MAX_CARDS-1:0] player_symbols,
  output logic [4*MAX_CARDS-1:0] dealer_values,
  output logic [2*MAX_CARDS-1:0] dealer_symbols,
  output logic [3:0]             player_count,
  output logic [3:0]             dealer_count,
  output logic [SCORE_W-1:0]     player_score,
  output logic [SCORE_W-1:0]     dealer_score,
  output logic [2:0]             state_btn,
  output logic [1:0]             result
);
  typedef enum logic [3:0] {
    IDLE, DEAL, CHECK_NATURAL, PLAYER_TURN, PLAYER_DRAW, PLAYER_CHECK,
    DEALER_TURN, DEALER_DRAW, DEALER_WAIT, RESOLVE, DONE
  } state_t;
  state_t state;
  logic [3:0] pv [MAX_CARDS];
  logic [1:0] psy [MAX_CARDS];
  logic [3:0] dv [MAX_CARDS];
  logic [1:0] dsy [MAX_CARDS];
  logic deal_q, hit_q, stand_q, deal_e, hit_e, stand_e;
  logic [1:0] deal_idx;
  logic take, to_p, to_d;
  logic [7:0] p_sum, d_sum, p_tot, d_tot;
  logic p_ace, d_ace, p_bust, d_bust, p_room, d_room, d_draw;
  function automatic logic [7:0] pts(input logic [3:0] v);
    return v >= 4'd10 ? 8'd10 : {4'd0, v};
  endfunction
  function automatic logic [SCORE_W-1:0] sat(input logic [7:0] s);
    return int'(s) > (1 << SCORE_W) - 1 ? '1 : SCORE_W'(s);
  endfunction
  assign deal_e  = deal & ~deal_q;
  assign hit_e   = hit & ~hit_q;
  assign stand_e = stand & ~stand_q;
  assign take    = card_req & card_valid;
  assign to_p    = (state == DEAL && !deal_idx[0]) || state == PLAYER_DRAW;
  assign to_d    = (state == DEAL && deal_idx[0]) || state == DEALER_DRAW;
  assign p_bust  = p_tot > 8'd21;
  assign d_bust  = d_tot > 8'd21;
  assign p_room  = int'(player_count) < MAX_CARDS;
  assign d_room  = int'(dealer_count) < MAX_CARDS;
  // Totals come straight from the hand registers so decisions see the post-update score.
  always_comb begin
    p_sum = '0;
    d_sum = '0;
    p_ace = 1'b0;
    d_ace = 1'b0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      p_sum = p_sum + pts(pv[i]);
      d_sum = d_sum + pts(dv[i]);
      p_ace = p_ace | (pv[i] == 4'd1);
      d_ace = d_ace | (dv[i] == 4'd1);
    end
    p_tot = p_sum + ((p_ace && p_sum <= 8'd11) ? 8'd10 : 8'd0);
    d_tot = d_sum + ((d_ace && d_sum <= 8'd11) ? 8'd10 : 8'd0);
  end
`ifdef DEALER_HIT_SOFT17_EN
  logic d_soft;
  assign d_soft = d_ace && d_sum <= 8'd11;
  assign d_draw = int'(d_tot) < DEALER_STAND || (int'(d_tot) == DEALER_STAND && d_soft);
`else
  assign d_draw = int'(d_tot) < DEALER_STAND;
`endif
  genvar g;
  for (g = 0; g < MAX_CARDS; g++) begin : g_flat
    assign player_values[4*g +: 4]  = pv[g];
    assign player_symbols[2*g +: 2] = psy[g];
    assign dealer_values[4*g +: 4]  = dv[g];
    assign dealer_symbols[2*g +: 2] = dsy[g];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      card_req     <= 1'b0;
      deal_q       <= 1'b0;
      hit_q        <= 1'b0;
      stand_q      <= 1'b0;
      deal_idx     <= '0;
      player_count <= '0;
      dealer_count <= '0;
      player_score <= '0;
      dealer_score <= '0;
      state_btn    <= '0;
      result       <= '0;
      for (int i = 0; i < MAX_CARDS; i++) begin
        pv[i]  <= '0;
        psy[i] <= '0;
        dv[i]  <= '0;
        dsy[i] <= '0;
      end
    end else begin
      deal_q       <= deal;
      hit_q        <= hit;
      stand_q      <= stand;
      player_score <= sat(p_tot);
      dealer_score <= sat(d_tot);
      if (take) begin
        card_req <= 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
          if (to_p && i == int'(player_count)) begin
            pv[i]  <= card_value;
            psy[i] <= card_symbol;
          end
          if (to_d && i == int'(dealer_count)) begin
            dv[i]  <= card_value;
            dsy[i] <= card_symbol;
          end
        end
        if (to_p) player_count <= player_count + 4'd1;
        if (to_d) dealer_count <= dealer_count + 4'd1;
      end
      case (state)
        IDLE, DONE: if (deal_e) begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            pv[i]  <= '0;
            psy[i] <= '0;
            dv[i]  <= '0;
            dsy[i] <= '0;
          end
          player_count <= '0;
          dealer_count <= '0;
          result       <= '0;
          deal_idx     <= '0;
          state_btn    <= 3'd0;
          state        <= DEAL;
        end
        DEAL: if (take) begin
          deal_idx <= deal_idx + 2'd1;
          if (deal_idx == 2'd3) state <= CHECK_NATURAL;
        end else card_req <= 1'b1;
        CHECK_NATURAL: begin
          state     <= p_tot == 8'd21 ? DEALER_TURN : PLAYER_TURN;
          state_btn <= p_tot == 8'd21 ? 3'd2 : 3'd1;
        end
        // Stand is checked first so a simultaneous hit is dropped.
        PLAYER_TURN: if (stand_e) begin
          state     <= DEALER_TURN;
          state_btn <= 3'd2;
        end else if (hit_e && p_room) state <= PLAYER_DRAW;
        PLAYER_DRAW: if (take) state <= PLAYER_CHECK;
        else card_req <= 1'b1;
        PLAYER_CHECK: if (p_bust) state <= RESOLVE;
        else if (p_tot == 8'd21 || !p_room) begin
          state     <= DEALER_TURN;
          state_btn <= 3'd2;
        end else state <= PLAYER_TURN;
        DEALER_TURN: state <= d_draw && d_room ? DEALER_DRAW : RESOLVE;
        DEALER_DRAW: if (take) state <= DEALER_WAIT;
        else card_req <= 1'b1;
        DEALER_WAIT: state <= DEALER_TURN;
        RESOLVE: begin
          result    <= p_bust ? 2'd2 : d_bust ? 2'd1 : p_tot > d_tot ? 2'd1 : p_tot < d_tot ? 2'd2 : 2'd3;
          state_btn <= 3'd3;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blackjack_table_fsm.sv
// tb_blackjack_table_fsm: directed vector table, corner sequences and random rounds
// checked against a list-based blackjack rules model.
module tb_blackjack_table_fsm;
  localparam int MAXC  = 9;
  localparam int STAND = 17;
  typedef int iq_t[$];
  typedef struct {
    int c[6];
    int hits;
    bit st;
    int res, ps, ds, pc, dc;
  } vec_t;
  logic clk = 0, rst = 0, deal = 0, hit = 0, stand = 0, card_valid = 0;
  logic [3:0] card_value = 0;
  logic [1:0] card_symbol = 0;
  logic card_req;
  logic [4*MAXC-1:0] player_values, dealer_values;
  logic [2*MAXC-1:0] player_symbols, dealer_symbols;
  logic [3:0] player_count, dealer_count;
  logic [5:0] player_score, dealer_score;
  logic [2:0] state_btn;
  logic [1:0] result;
  int compared = 0, mismatched = 0;
  logic [5:0] src_q[$];
  int syms[$];
  int src_delay = 0, drops = 0, req_hi = 0;
  bit src_spur = 0, mon_en = 0;

  always #5 clk = ~clk;

  blackjack_table_fsm #(.MAX_CARDS(MAXC), .SCORE_W(6), .DEALER_STAND(STAND)) dut (
    .clk(clk), .rst(rst), .deal(deal), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_value(card_value), .card_symbol(card_symbol),
    .card_req(card_req), .player_values(player_values), .player_symbols(player_symbols),
    .dealer_values(dealer_values), .dealer_symbols(dealer_symbols),
    .player_count(player_count), .dealer_count(dealer_count),
    .player_score(player_score), .dealer_score(dealer_score),
    .state_btn(state_btn), .result(result)
  );

  // Card source: answers card_req after src_delay cycles, optionally flags dropped requests.
  initial begin : source
    int wait_cnt;
    bit prev_req, prev_val;
    wait_cnt = 0;
    prev_req = 0;
    prev_val = 0;
    forever begin
      @(negedge clk);
      if (mon_en && prev_req && !prev_val && !card_req) drops++;
      if (mon_en && card_req) req_hi++;
      prev_req = card_req;
      if (card_req && src_q.size() > 0 && wait_cnt >= src_delay) begin
        {card_value, card_symbol} = src_q.pop_front();
        card_valid = 1;
        wait_cnt = 0;
      end else begin
        if (card_req) wait_cnt++;
        card_valid = !card_req && src_spur;
      end
      prev_val = card_valid;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_btn(input int v, input int lim, input string nm);
    int n = 0;
    while (int'(state_btn) != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(state_btn), v);
  endtask

  task automatic wait_pc(input int v, input int lim);
    int n = 0;
    while (int'(player_count) != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("hit_card_arrives", int'(player_count), v);
  endtask

  task automatic pulse(input int w);
    if (w == 0) deal = 1;
    else if (w == 1) hit = 1;
    else stand = 1;
    @(negedge clk);
    deal = 0;
    hit = 0;
    stand = 0;
  endtask

  task automatic play(input iq_t d, input int hits, input bit st, input string tag);
    src_q.delete();
    syms.delete();
    foreach (d[i]) begin
      int s;
      s = $urandom_range(0, 3);
      syms.push_back(s);
      src_q.push_back({4'(d[i]), 2'(s)});
    end
    pulse(0);
    for (int k = 0; k < hits; k++) begin
      wait_btn(1, 1000, {tag, "_turn"});
      pulse(1);
      wait_pc(3 + k, 1000);
      @(negedge clk);
    end
    if (st) begin
      wait_btn(1, 1000, {tag, "_stand_turn"});
      pulse(2);
    end
    wait_btn(3, 4000, {tag, "_done"});
    @(negedge clk);
  endtask

  function automatic int score(iq_t v);
    int s = 0;
    bit a = 0;
    foreach (v[i]) begin
      s += v[i] > 10 ? 10 : v[i];
      a |= v[i] == 1;
    end
    return (a && s + 10 <= 21) ? s + 10 : s;
  endfunction

  function automatic bit dealer_hits(iq_t v);
    int s = score(v);
`ifdef DEALER_HIT_SOFT17_EN
    int h = 0;
    foreach (v[i]) h += v[i] > 10 ? 10 : v[i];
    return s < STAND || (s == STAND && s != h);
`else
    return s < STAND;
`endif
  endfunction

  function automatic iq_t vals(iq_t d, iq_t idx);
    iq_t r;
    foreach (idx[i]) r.push_back(d[idx[i]]);
    return r;
  endfunction

  function automatic int judge(iq_t p, iq_t q);
    int ps = score(p), ds = score(q);
    if (ps > 21) return 2;
    if (ds > 21) return 1;
    if (ps != ds) return ps > ds ? 1 : 2;
    return 3;
  endfunction

  // Round outcome from the rules: deal order, player hits below threshold t, dealer auto-play.
  task automatic model(input iq_t d, input int t, output iq_t pi, output iq_t di,
                       output int hits, output bit st);
    int n = 4;
    pi = '{0, 2};
    di = '{1, 3};
    hits = 0;
    st = 0;
    while (1) begin
      int s = score(vals(d, pi));
      if (s >= 21 || pi.size() == MAXC) break;
      if (s >= t) begin
        st = 1;
        break;
      end
      pi.push_back(n++);
      hits++;
    end
    if (score(vals(d, pi)) <= 21)
      while (di.size() < MAXC && dealer_hits(vals(d, di))) di.push_back(n++);
  endtask

  task automatic rnd_round();
    iq_t d, pi, di, pv, dv;
    int h, t;
    bit st;
    for (int i = 0; i < 4 + 2 * MAXC; i++) d.push_back($urandom_range(1, 13));
    t = $urandom_range(12, 21);
    model(d, t, pi, di, h, st);
    play(d, h, st, "rnd");
    pv = vals(d, pi);
    dv = vals(d, di);
    chk("rnd_result", int'(result), judge(pv, dv));
    chk("rnd_pscore", int'(player_score), score(pv));
    chk("rnd_dscore", int'(dealer_score), score(dv));
    chk("rnd_pcount", int'(player_count), pi.size());
    chk("rnd_dcount", int'(dealer_count), di.size());
    for (int i = 0; i < MAXC; i++) begin
      int ev = 0, es = 0, fv = 0, fs = 0;
      if (i < pi.size()) begin ev = d[pi[i]]; es = syms[pi[i]]; end
      if (i < di.size()) begin fv = d[di[i]]; fs = syms[di[i]]; end
      chk("rnd_pval", int'(player_values[4*i +: 4]), ev);
      chk("rnd_psym", int'(player_symbols[2*i +: 2]), es);
      chk("rnd_dval", int'(dealer_values[4*i +: 4]), fv);
      chk("rnd_dsym", int'(dealer_symbols[2*i +: 2]), fs);
    end
  endtask

  function automatic vec_t mkv(int a, int b, int c, int d, int e, int f, int h, bit s,
                               int res, int ps, int ds, int pc, int dc);
    vec_t v;
    v.c[0] = a; v.c[1] = b; v.c[2] = c; v.c[3] = d; v.c[4] = e; v.c[5] = f;
    v.hits = h; v.st = s; v.res = res; v.ps = ps; v.ds = ds; v.pc = pc; v.dc = dc;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    iq_t d;
    int n;
    vecs.push_back(mkv(10, 5, 9, 7, 8, 0, 0, 1, 2, 19, 20, 2, 3));
    vecs.push_back(mkv(10, 10, 6, 7, 9, 0, 1, 0, 2, 25, 17, 3, 2));
    vecs.push_back(mkv(1, 10, 13, 7, 0, 0, 0, 0, 1, 21, 17, 2, 2));
    vecs.push_back(mkv(10, 10, 8, 8, 0, 0, 0, 1, 3, 18, 18, 2, 2));
    vecs.push_back(mkv(10, 10, 8, 6, 10, 0, 0, 1, 1, 18, 26, 2, 3));
`ifdef DEALER_HIT_SOFT17_EN
    vecs.push_back(mkv(10, 1, 8, 6, 4, 0, 0, 1, 2, 18, 21, 2, 3));
`else
    vecs.push_back(mkv(10, 1, 8, 6, 4, 0, 0, 1, 1, 18, 17, 2, 2));
`endif
    vecs.push_back(mkv(5, 10, 6, 7, 10, 0, 1, 0, 1, 21, 17, 3, 2));
    vecs.push_back(mkv(12, 11, 11, 13, 0, 0, 0, 1, 3, 20, 20, 2, 2));
    vecs.push_back(mkv(1, 10, 1, 9, 9, 0, 1, 0, 1, 21, 19, 3, 2));
    vecs.push_back(mkv(1, 9, 5, 8, 10, 0, 1, 1, 2, 16, 17, 3, 2));
    repeat (3) @(negedge clk);
    chk("rst_card_req", int'(card_req), 0);
    chk("rst_pcount", int'(player_count), 0);
    chk("rst_btn", int'(state_btn), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_pscore", int'(player_score), 0);
    rst = 1;
    @(negedge clk);
    foreach (vecs[k]) begin
      d.delete();
      for (int j = 0; j < 6; j++) if (vecs[k].c[j] != 0) d.push_back(vecs[k].c[j]);
      play(d, vecs[k].hits, vecs[k].st, $sformatf("row%0d", k));
      chk($sformatf("row%0d_result", k), int'(result), vecs[k].res);
      chk($sformatf("row%0d_pscore", k), int'(player_score), vecs[k].ps);
      chk($sformatf("row%0d_dscore", k), int'(dealer_score), vecs[k].ds);
      chk($sformatf("row%0d_pcount", k), int'(player_count), vecs[k].pc);
      chk($sformatf("row%0d_dcount", k), int'(dealer_count), vecs[k].dc);
    end
    src_spur = 1;
    repeat (5) @(negedge clk);
    src_spur = 0;
    @(negedge clk);
    chk("spurious_valid_pcount", int'(player_count), vecs[vecs.size()-1].pc);
    chk("spurious_valid_dcount", int'(dealer_count), vecs[vecs.size()-1].dc);
    // Held hit adds one card; then simultaneous hit+stand must only stand.
    src_q.delete();
    foreach (vecs[0].c[j]) src_q.push_back(6'd0);
    src_q.delete();
    src_q.push_back({4'd10, 2'd0}); src_q.push_back({4'd10, 2'd1});
    src_q.push_back({4'd2, 2'd2});  src_q.push_back({4'd3, 2'd3});
    src_q.push_back({4'd4, 2'd0});  src_q.push_back({4'd5, 2'd1});
    pulse(0);
    wait_btn(1, 1000, "hold_turn");
    hit = 1;
    repeat (100) @(negedge clk);
    chk("hold_hit_pcount", int'(player_count), 3);
    hit = 0;
    @(negedge clk);
    hit = 1;
    stand = 1;
    @(negedge clk);
    hit = 0;
    stand = 0;
    repeat (3) @(negedge clk);
    chk("hitstand_pcount", int'(player_count), 3);
    chk("hitstand_btn", int'(state_btn), 2);
    wait_btn(3, 1000, "hitstand_done");
    chk("hitstand_result", int'(result), 2);
    chk("hitstand_dscore", int'(dealer_score), 18);
    // Slow source: requests must be held until served.
    src_delay = 50;
    mon_en = 1;
    d = '{10, 5, 9, 7, 8};
    play(d, 0, 1, "slow");
    mon_en = 0;
    src_delay = 0;
    chk("slow_req_drops", drops, 0);
    chk("slow_req_held", int'(req_hi >= 250), 1);
    chk("slow_result", int'(result), 2);
    chk("slow_dcount", int'(dealer_count), 3);
    for (int r = 0; r < 30; r++) rnd_round();
    // Asynchronous reset in the middle of a pending request.
    src_q.delete();
    src_q.push_back({4'd7, 2'd2});
    pulse(0);
    n = 0;
    while (!(player_count == 4'd1 && card_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_deal_req", int'(card_req), 1);
    #2 rst = 0;
    #1;
    chk("mid_rst_card_req", int'(card_req), 0);
    chk("mid_rst_pcount", int'(player_count), 0);
    chk("mid_rst_dcount", int'(dealer_count), 0);
    chk("mid_rst_btn", int'(state_btn), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_pscore", int'(player_score), 0);
    chk("mid_rst_pvals", int'(player_values == '0), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
